// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 datapath, with a data-RAM timeout.
// Optional cycle/retire performance counters are enabled by defining MCTRL_PERF_CNT_EN.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             lw_en,
   input  logic             sw_en,
   input  logic             wr_en,
   input  logic             offset_en,
   input  logic             mux_sel,
   input  logic             br_taken,
   input  logic             mem_ack,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel_offset,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             reg_we,
   output logic             busy,
   output logic             bus_err,
   output logic [2:0]       state
`ifdef MCTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      ERR    = 3'd7
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     cur_state;
   logic [7:0] tmo_cnt;
   logic [7:0] mem_cycle;

   // tmo_cnt holds completed MEM cycles, so mem_cycle is the 1-based index of the current one
   assign mem_cycle = tmo_cnt + 8'd1;
   assign state     = cur_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= IDLE;
         tmo_cnt   <= 8'd0;
      end else begin
         case (cur_state)
            IDLE:    if (run) cur_state <= FETCH;
            FETCH:   cur_state <= DECODE;
            DECODE:  cur_state <= EXEC;
            EXEC: begin
               if (lw_en && sw_en) begin
                  cur_state <= ERR;
               end else if (lw_en || sw_en) begin
                  cur_state <= MEM;
                  tmo_cnt   <= 8'd0;
               end else begin
                  cur_state <= WB;
               end
            end
            // an ack on the final allowed cycle still completes the access
            MEM: begin
               if (mem_ack)                   cur_state <= WB;
               else if (mem_cycle == TIMEOUT) cur_state <= ERR;
               else                           tmo_cnt   <= mem_cycle;
            end
            WB:      cur_state <= run ? FETCH : IDLE;
            ERR:     cur_state <= ERR;
            default: cur_state <= ERR;
         endcase
      end
   end

   always_comb begin
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel_offset = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      reg_we        = 1'b0;
      busy          = 1'b0;
      bus_err       = 1'b0;
      case (cur_state)
         IDLE: ;
         FETCH: begin
            ir_we = 1'b1;
            busy  = 1'b1;
         end
         DECODE, EXEC: busy = 1'b1;
         MEM: begin
            mem_rd = lw_en;
            mem_wr = sw_en;
            busy   = 1'b1;
         end
         WB: begin
            pc_we         = 1'b1;
            reg_we        = wr_en & ~sw_en;
            pc_sel_offset = mux_sel | (offset_en & br_taken);
            busy          = 1'b1;
         end
         default: bus_err = 1'b1;
      endcase
   end

`ifdef MCTRL_PERF_CNT_EN
   // busy is low in ERR, so both counters freeze there without extra gating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (busy)            cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (cur_state == WB) ret_cnt <= ret_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instruction streams
// compared cycle-by-cycle against per-phase expectations derived from the instruction type.
module tb_multicycle_ctrl;

   localparam int T = 15;

   logic clk = 1'b0;
   logic rst, run, lw_en, sw_en, wr_en, offset_en, mux_sel, br_taken, mem_ack;
   logic ir_we, pc_we, pc_sel_offset, mem_rd, mem_wr, reg_we, busy, bus_err;
   logic [2:0] state;
   int tests = 0;
   int fails = 0;
`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] cyc_cnt, ret_cnt;
   logic [31:0] exp_cyc = 32'd0;
   logic [31:0] exp_ret = 32'd0;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .run(run),
      .lw_en(lw_en), .sw_en(sw_en), .wr_en(wr_en), .offset_en(offset_en),
      .mux_sel(mux_sel), .br_taken(br_taken), .mem_ack(mem_ack),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel_offset(pc_sel_offset),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we),
      .busy(busy), .bus_err(bus_err), .state(state)
`ifdef MCTRL_PERF_CNT_EN
      , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
   );

   always #5 clk = ~clk;

   // expected vector layout: {state, ir_we, pc_we, pc_sel_offset, mem_rd, mem_wr, reg_we, busy, bus_err}
   function automatic logic [10:0] mk(input logic [2:0] st, input logic [7:0] f);
      return {st, f};
   endfunction

   localparam logic [10:0] E_IDLE   = {3'd0, 8'b0000_0000};
   localparam logic [10:0] E_FETCH  = {3'd1, 8'b1000_0010};
   localparam logic [10:0] E_DECODE = {3'd2, 8'b0000_0010};
   localparam logic [10:0] E_EXEC   = {3'd3, 8'b0000_0010};
   localparam logic [10:0] E_ERR    = {3'd7, 8'b0000_0001};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [10:0] exp);
      logic [10:0] obs;
      #1;
      obs = {state, ir_we, pc_we, pc_sel_offset, mem_rd, mem_wr, reg_we, busy, bus_err};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
`ifdef MCTRL_PERF_CNT_EN
      tests++;
      assert (cyc_cnt === exp_cyc) else begin
         fails++;
         $error("[TB] FAIL %s cyc_cnt: observed %0d expected %0d", tag, cyc_cnt, exp_cyc);
      end
      tests++;
      assert (ret_cnt === exp_ret) else begin
         fails++;
         $error("[TB] FAIL %s ret_cnt: observed %0d expected %0d", tag, ret_cnt, exp_ret);
      end
      if (exp[1]) exp_cyc = exp_cyc + 32'd1;
      if (exp[10:8] == 3'd5) exp_ret = exp_ret + 32'd1;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      mem_ack = 1'b0;
`ifdef MCTRL_PERF_CNT_EN
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
`endif
      check_output("in_reset", E_IDLE);
      step();
      rst = 1'b0;
      check_output("after_release", E_IDLE);
   endtask

   task automatic idle_cycle(input logic r);
      step();
      run = r;
      check_output("idle", E_IDLE);
   endtask

   // One instruction starting in FETCH; ack_at is the MEM cycle carrying mem_ack, 0 = never
   task automatic apply_stimulus(input string tag, input logic lw, input logic sw, input logic wr,
                                 input logic off, input logic jal, input logic br,
                                 input int ack_at, input logic run_after);
      step();
      lw_en = lw; sw_en = sw; wr_en = wr; offset_en = off; mux_sel = jal; br_taken = br;
      mem_ack = 1'b0;
      run = 1'($urandom);
      check_output({tag, "_fetch"}, E_FETCH);
      step();
      run = 1'($urandom);
      check_output({tag, "_decode"}, E_DECODE);
      step();
      run = 1'($urandom);
      check_output({tag, "_exec"}, E_EXEC);
      if (lw && sw) begin
         step();
         check_output({tag, "_illegal_err"}, E_ERR);
         return;
      end
      if (lw || sw) begin
         for (int i = 1; i <= T; i++) begin
            step();
            mem_ack = (i == ack_at);
            run = 1'($urandom);
            check_output({tag, "_mem"}, mk(3'd4, {3'b000, lw, sw, 3'b010}));
            if (i == ack_at) break;
         end
         if (ack_at < 1 || ack_at > T) begin
            step();
            mem_ack = 1'b0;
            check_output({tag, "_timeout_err"}, E_ERR);
            return;
         end
      end
      step();
      mem_ack = 1'b0;
      run = run_after;
      check_output({tag, "_wb"}, mk(3'd5, {2'b01, jal | (off & br), 2'b00, wr & ~sw, 2'b10}));
   endtask

   initial begin
      {run, lw_en, sw_en, wr_en, offset_en, mux_sel, br_taken, mem_ack} = '0;
      rst = 1'b1;
      #2;
      do_reset();

      // two ALU instructions straight from reset, then park
      idle_cycle(1'b1);
      apply_stimulus("alu1", 0, 0, 1, 0, 0, 0, 0, 1'b1);
      apply_stimulus("alu2", 0, 0, 1, 0, 0, 0, 0, 1'b0);
      idle_cycle(1'b0);
`ifdef MCTRL_PERF_CNT_EN
      tests++;
      assert (cyc_cnt === 32'd8 && ret_cnt === 32'd2) else begin
         fails++;
         $error("[TB] FAIL perf_two_alu: observed %0d/%0d expected 8/2", cyc_cnt, ret_cnt);
      end
`endif
      idle_cycle(1'b1);

      apply_stimulus("br_nt", 0, 0, 0, 1, 0, 0, 0, 1'b1);
      apply_stimulus("br_t",  0, 0, 0, 1, 0, 1, 0, 1'b1);
      apply_stimulus("jal",   0, 0, 1, 1, 1, 0, 0, 1'b1);
      apply_stimulus("load3", 1, 0, 1, 0, 0, 0, 3, 1'b1);
      apply_stimulus("load_at_timeout", 1, 0, 1, 0, 0, 0, T, 1'b1);
      apply_stimulus("store1", 0, 1, 1, 0, 0, 0, 1, 1'b1);

      for (int n = 0; n < 30; n++) begin
         int kind;
         logic ra;
         kind = $urandom_range(0, 4);
         ra = ($urandom_range(0, 3) != 0);
         case (kind)
            0: apply_stimulus("r_alu", 0, 0, 1'($urandom), 0, 0, 1'($urandom), 0, ra);
            1: apply_stimulus("r_br", 0, 0, 1'($urandom), 1, 0, 1'($urandom), 0, ra);
            2: apply_stimulus("r_jal", 0, 0, 1, 1'($urandom), 1, 1'($urandom), 0, ra);
            3: apply_stimulus("r_load", 1, 0, 1'($urandom), 0, 0, 0, $urandom_range(1, T), ra);
            default: apply_stimulus("r_store", 0, 1, 1'($urandom), 0, 0, 0, $urandom_range(1, T), ra);
         endcase
         if (!ra) begin
            for (int k = 0; k < $urandom_range(0, 3); k++) idle_cycle(1'b0);
            idle_cycle(1'b1);
         end
      end

      // store that never sees an ack: 15 MEM cycles then sticky error
      apply_stimulus("store_tmo", 0, 1, 0, 0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         run = 1'b1;
         mem_ack = 1'($urandom);
         check_output("err_sticky", E_ERR);
      end
      do_reset();

      // illegal decode (load and store together)
      idle_cycle(1'b1);
      apply_stimulus("illegal", 1, 1, 0, 0, 0, 0, 0, 1'b1);
      step();
      check_output("illegal_sticky", E_ERR);
      do_reset();

      // reset during the second MEM cycle of a load
      idle_cycle(1'b1);
      step();
      lw_en = 1; sw_en = 0; wr_en = 1; offset_en = 0; mux_sel = 0; br_taken = 0; mem_ack = 0;
      check_output("rl_fetch", E_FETCH);
      step();
      check_output("rl_decode", E_DECODE);
      step();
      check_output("rl_exec", E_EXEC);
      step();
      check_output("rl_mem1", mk(3'd4, 8'b0001_0010));
      step();
      check_output("rl_mem2", mk(3'd4, 8'b0001_0010));
      do_reset();
      for (int k = 0; k < 3; k++) idle_cycle(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
